pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage pipeline. Generates stall/flush controls
//  for the IF, IF/ID and ID/EX stages: load-use stalls, taken-branch squash of IF/ID, and
//  interlocks for the multi-cycle MULT/DIV unit in EX. Tracks the MULT/DIV unit with a
//  counter FSM and keeps a saturating count of stall cycles for performance checks.
// PARAMETERS
//  MULT_CYCLES  4   EX occupancy of MULT/MULTU, in cycles (>=1)
//  DIV_CYCLES   32  EX occupancy of DIV/DIVU, in cycles (>=1)
//  CNT_W        6   width of the MULT/DIV down-counter; must hold max(MULT_CYCLES,DIV_CYCLES)-1
//  STALL_CNT_W  16  width of the stall-cycle counter
// PORTS
//  clk            in   1            rising-edge clock
//  rst_n          in   1            synchronous reset, active-low
//  RsD            in   5            rs field of instruction in ID
//  RtD            in   5            rt field of instruction in ID
//  RtE            in   5            rt (load destination) of instruction in EX
//  MemtoRegE      in   1            instruction in EX is a load
//  BranchTakenD   in   1            branch/jump in ID resolved taken
//  MulDivStartD   in   1            instruction in ID is MULT/MULTU/DIV/DIVU
//  MulDivOpD      in   1            0 = multiply, 1 = divide (valid with MulDivStartD)
//  MfHiLoD        in   1            instruction in ID reads HI/LO (MFHI/MFLO)
//  StallF         out  1            hold PC
//  StallD         out  1            hold IF/ID register
//  FlushD         out  1            clear IF/ID register (taken-branch squash)
//  FlushE         out  1            load a bubble (all control bits 0) into ID/EX
//  MulDivBusy     out  1            MULT/DIV unit occupied (state != IDLE)
//  MulDivOpE      out  1            op latched at start (0 mult, 1 div)
//  MulDivDone     out  1            one-cycle pulse: write HI/LO this cycle
//  StallCount     out  STALL_CNT_W  saturating count of cycles with StallD=1
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, counter=0, MulDivOpE=0, StallCount=0; hence
//   MulDivBusy=0, MulDivDone=0. Reset mid-BUSY aborts the operation with no Done pulse.
//  Combinational hazard terms (same cycle as inputs):
//   lu  = MemtoRegE & (RtE!=0) & ((RtE==RsD) | (RtE==RtD))
//   md  = (state!=IDLE) & (MfHiLoD | MulDivStartD)
//   stall = lu | md;  StallF = StallD = FlushE = stall
//   FlushD = BranchTakenD & ~stall  (stall wins; the branch is re-evaluated next cycle)
//  FSM states IDLE, BUSY, DONE:
//   IDLE: if MulDivStartD & ~stall -> BUSY, counter <= (MulDivOpD ? DIV_CYCLES : MULT_CYCLES)-1,
//         MulDivOpE <= MulDivOpD. Start coincident with lu is not accepted (stays IDLE).
//   BUSY: counter==0 -> DONE, else counter <= counter-1.
//   DONE: MulDivDone=1 for exactly this cycle; -> IDLE unconditionally.
//  Timeline (start accepted at cycle T, N = op cycles): BUSY T+1..T+N, DONE T+N+1,
//   IDLE from T+N+2. MulDivBusy=1 over T+1..T+N+1. A MFHI/MFLO or second MULT/DIV in ID
//   stalls through T+N+1 and advances at T+N+2 (HI/LO already written in DONE).
//  MulDivBusy and MulDivDone are decoded from registered state only (no input paths).
//  StallCount: +1 on each cycle with stall=1; holds at all-ones (no wrap).
//  RtE==0 never produces a load-use stall. Independent instructions in ID proceed during BUSY.
// TESTING
//  1 Load-use: MemtoRegE=1,RtE=5,RsD=5 -> StallF=StallD=FlushE=1 same cycle; RtE=0,RsD=0 -> all 0.
//  2 MULT, MULT_CYCLES=4, start at T, MfHiLoD=1 from T+1 -> Busy T+1..T+5, Done only at T+5,
//    StallD=1 T+1..T+5, 0 at T+6.
//  3 DIV, DIV_CYCLES=32 -> MulDivOpE=1, Done exactly 33 cycles after start cycle, single pulse.
//  4 BranchTakenD=1 with lu=1 -> FlushD=0, StallD=1; next cycle lu=0 -> FlushD=1, StallD=0.
//  5 MulDivStartD with lu=1 -> stays IDLE, Busy=0; lu drops next cycle -> Busy=1 following cycle.
//  6 rst_n=0 at counter=2 in BUSY -> next cycle Busy=0, Done=0, StallCount=0, no later Done;
//    STALL_CNT_W=4 held stall 20 cycles -> StallCount=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and sequencing controller for a 5-stage pipeline. Produces the
//   stall/flush controls for the IF, IF/ID and ID/EX stages:
//     - load-use stalls against the load in EX,
//     - squash of IF/ID on a taken branch/jump in ID,
//     - interlocks against the multi-cycle MULT/DIV unit in EX.
//   The MULT/DIV unit is tracked by a small down-counter FSM
//   (IDLE -> BUSY -> DONE -> IDLE). A saturating counter records how many
//   cycles the decode stage was held, for performance checks.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   RsD, RtD       source register fields of the instruction in ID
//   RtE            destination of the (possible) load in EX
//   MemtoRegE      instruction in EX is a load
//   BranchTakenD   branch/jump in ID resolved taken
//   MulDivStartD   instruction in ID is MULT/MULTU/DIV/DIVU
//   MulDivOpD      0 = multiply, 1 = divide (valid with MulDivStartD)
//   MfHiLoD        instruction in ID reads HI/LO
//   StallF         hold PC
//   StallD         hold IF/ID register
//   FlushD         clear IF/ID register
//   FlushE         insert a bubble into ID/EX
//   MulDivBusy     MULT/DIV unit occupied (state not IDLE)
//   MulDivOpE      operation latched when the unit was started
//   MulDivDone     one-cycle pulse, HI/LO written this cycle
//   StallCount     saturating count of cycles with StallD=1
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             RsD,
    input  logic [4:0]             RtD,
    input  logic [4:0]             RtE,
    input  logic                   MemtoRegE,
    input  logic                   BranchTakenD,
    input  logic                   MulDivStartD,
    input  logic                   MulDivOpD,
    input  logic                   MfHiLoD,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic                   MulDivBusy,
    output logic                   MulDivOpE,
    output logic                   MulDivDone,
    output logic [STALL_CNT_W-1:0] StallCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // Counter reload values: the counter runs N-1 .. 0, giving N BUSY cycles.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] SC_ZERO = {STALL_CNT_W{1'b0}};
    localparam logic [STALL_CNT_W-1:0] SC_ONE  = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] SC_MAX  = {STALL_CNT_W{1'b1}};

    md_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   op_q, op_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu_s;
    logic md_s;
    logic stall_s;

    // Hazard detection: load-use against EX, and HI/LO or unit reuse while occupied.
    always_comb begin
        lu_s    = 1'b0;
        md_s    = 1'b0;
        stall_s = 1'b0;
        if (MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD))) begin
            lu_s = 1'b1;
        end else begin
            lu_s = 1'b0;
        end
        if ((state_q != ST_IDLE) && (MfHiLoD || MulDivStartD)) begin
            md_s = 1'b1;
        end else begin
            md_s = 1'b0;
        end
        stall_s = lu_s | md_s;
    end

    // Pipeline controls; a stall overrides the branch squash so the branch
    // is re-evaluated once the hazard clears.
    always_comb begin
        StallF = stall_s;
        StallD = stall_s;
        FlushE = stall_s;
        FlushD = BranchTakenD & ~stall_s;
    end

    // MULT/DIV sequencing: next state, counter, latched op, decoded status.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                // A start that collides with any stall is not accepted here;
                // ID holds it and it is presented again next cycle.
                if (MulDivStartD && !stall_s) begin
                    state_d = ST_BUSY;
                    cnt_d   = MulDivOpD ? DIV_LOAD : MULT_LOAD;
                    op_d    = MulDivOpD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        // Status flags are registered copies of the next state so they carry
        // no combinational path from the inputs.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Saturating stall-cycle counter.
    always_comb begin
        if (stall_s && (stall_cnt_q != SC_MAX)) begin
            stall_cnt_d = stall_cnt_q + SC_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            op_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stall_cnt_q <= SC_ZERO;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign MulDivBusy = busy_q;
    assign MulDivDone = done_q;
    assign MulDivOpE  = op_q;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed self-checking bench for pipe_hazard_ctrl. A second instance with a
//   4-bit stall counter shares the stimulus to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  RsD, RtD, RtE;
    logic        MemtoRegE, BranchTakenD, MulDivStartD, MulDivOpD, MfHiLoD;
    logic        StallF, StallD, FlushD, FlushE;
    logic        MulDivBusy, MulDivOpE, MulDivDone;
    logic [15:0] StallCount;
    logic        s_StallF, s_StallD, s_FlushD, s_FlushE;
    logic        s_MulDivBusy, s_MulDivOpE, s_MulDivDone;
    logic [3:0]  s_StallCount;

    int checks_r;
    int errors_r;

    pipe_hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RtE(RtE),
        .MemtoRegE(MemtoRegE), .BranchTakenD(BranchTakenD),
        .MulDivStartD(MulDivStartD), .MulDivOpD(MulDivOpD), .MfHiLoD(MfHiLoD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .MulDivBusy(MulDivBusy), .MulDivOpE(MulDivOpE), .MulDivDone(MulDivDone),
        .StallCount(StallCount)
    );

    pipe_hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .RsD(RsD), .RtD(RtD), .RtE(RtE),
        .MemtoRegE(MemtoRegE), .BranchTakenD(BranchTakenD),
        .MulDivStartD(MulDivStartD), .MulDivOpD(MulDivOpD), .MfHiLoD(MfHiLoD),
        .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
        .MulDivBusy(s_MulDivBusy), .MulDivOpE(s_MulDivOpE), .MulDivDone(s_MulDivDone),
        .StallCount(s_StallCount)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RsD = 5'd0; RtD = 5'd0; RtE = 5'd0;
        MemtoRegE = 1'b0; BranchTakenD = 1'b0;
        MulDivStartD = 1'b0; MulDivOpD = 1'b0; MfHiLoD = 1'b0;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        #1;
        check_eq({tag, "_StallF"}, {31'd0, StallF}, {31'd0, exp});
        check_eq({tag, "_StallD"}, {31'd0, StallD}, {31'd0, exp});
        check_eq({tag, "_FlushE"}, {31'd0, FlushE}, {31'd0, exp});
    endtask

    initial begin
        int done_cycle;
        int done_pulses;
        checks_r = 0;
        errors_r = 0;
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
        // Reset state
        check_eq("rst_busy", {31'd0, MulDivBusy}, 32'd0);
        check_eq("rst_done", {31'd0, MulDivDone}, 32'd0);
        check_eq("rst_ope",  {31'd0, MulDivOpE},  32'd0);
        check_eq("rst_cnt",  {16'd0, StallCount}, 32'd0);
        check_stall("rst", 1'b0);

        // Load-use on rs
        MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5; RtD = 5'd1;
        check_stall("lu_rs", 1'b1);
        step();
        check_eq("cnt_after_lu1", {16'd0, StallCount}, 32'd1);
        // RtE == 0 never stalls
        RtE = 5'd0; RsD = 5'd0;
        check_stall("lu_zero", 1'b0);
        step();
        // Load-use on rt
        RtE = 5'd7; RtD = 5'd7; RsD = 5'd3;
        check_stall("lu_rt", 1'b1);
        step();
        check_eq("cnt_after_lu2", {16'd0, StallCount}, 32'd2);
        // Matching register but EX is not a load
        MemtoRegE = 1'b0;
        check_stall("no_load", 1'b0);
        step();

        // Taken branch blocked by load-use, then squashes once it clears
        MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd9; BranchTakenD = 1'b1;
        #1;
        check_eq("br_lu_flushd", {31'd0, FlushD}, 32'd0);
        check_eq("br_lu_stalld", {31'd0, StallD}, 32'd1);
        step();
        MemtoRegE = 1'b0;
        #1;
        check_eq("br_flushd", {31'd0, FlushD}, 32'd1);
        check_eq("br_stalld", {31'd0, StallD}, 32'd0);
        step();
        BranchTakenD = 1'b0;
        check_eq("cnt_after_br", {16'd0, StallCount}, 32'd3);

        // MULT start colliding with load-use is refused
        MemtoRegE = 1'b1; RtE = 5'd4; RsD = 5'd4;
        MulDivStartD = 1'b1; MulDivOpD = 1'b0;
        check_stall("md_lu", 1'b1);
        step();
        check_eq("md_lu_busy", {31'd0, MulDivBusy}, 32'd0);
        // Load-use drops: start accepted in this cycle (T)
        MemtoRegE = 1'b0;
        check_stall("md_start", 1'b0);
        step();
        // T+1 .. T+5 with MFHI waiting in ID
        MulDivStartD = 1'b0; MfHiLoD = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check_eq($sformatf("mul_busy_%0d", i), {31'd0, MulDivBusy}, 32'd1);
            check_eq($sformatf("mul_stall_%0d", i), {31'd0, StallD}, 32'd1);
            check_eq($sformatf("mul_done_%0d", i), {31'd0, MulDivDone}, (i == 5) ? 32'd1 : 32'd0);
            step();
        end
        #1;
        check_eq("mul_busy_end",  {31'd0, MulDivBusy}, 32'd0);
        check_eq("mul_stall_end", {31'd0, StallD},     32'd0);
        check_eq("mul_done_end",  {31'd0, MulDivDone}, 32'd0);
        check_eq("mul_ope",       {31'd0, MulDivOpE},  32'd0);
        check_eq("cnt_after_mul", {16'd0, StallCount}, 32'd9);
        MfHiLoD = 1'b0;

        // DIV: Done exactly 33 cycles after the start cycle, one pulse
        MulDivStartD = 1'b1; MulDivOpD = 1'b1;
        step();
        MulDivStartD = 1'b0; MulDivOpD = 1'b0;
        check_eq("div_ope", {31'd0, MulDivOpE}, 32'd1);
        done_cycle  = 0;
        done_pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            if (MulDivDone) begin
                done_pulses++;
                if (done_cycle == 0) done_cycle = k;
            end
            step();
        end
        check_eq("div_done_cycle",  done_cycle,  32'd33);
        check_eq("div_done_pulses", done_pulses, 32'd1);
        check_eq("div_idle_after",  {31'd0, MulDivBusy}, 32'd0);

        // Reset mid-BUSY aborts without a Done pulse
        MulDivStartD = 1'b1;
        step();               // T+1, counter 3
        MulDivStartD = 1'b0;
        step();               // T+2, counter 2
        check_eq("abort_busy_pre", {31'd0, MulDivBusy}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("abort_busy", {31'd0, MulDivBusy}, 32'd0);
        check_eq("abort_done", {31'd0, MulDivDone}, 32'd0);
        check_eq("abort_cnt",  {16'd0, StallCount}, 32'd0);
        done_pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (MulDivDone || MulDivBusy) done_pulses++;
            step();
        end
        check_eq("abort_no_done", done_pulses, 32'd0);

        // Held load-use for 20 cycles: 16-bit counts 20, 4-bit saturates at 15
        MemtoRegE = 1'b1; RtE = 5'd12; RtD = 5'd12; RsD = 5'd0;
        for (int k = 0; k < 20; k++) step();
        idle_inputs();
        check_eq("sat_cnt_wide",  {16'd0, StallCount},   32'd20);
        check_eq("sat_cnt_small", {28'd0, s_StallCount}, 32'd15);
        step();
        check_eq("sat_cnt_hold",  {28'd0, s_StallCount}, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
